// File: rtl/os_rx_qualifier_pkg.sv
// Shared codes and state type for the ordered-set receive qualifier.
package os_rx_qualifier_pkg;

    localparam logic [3:0] OS_SLOS1  = 4'd0;
    localparam logic [3:0] OS_SLOS2  = 4'd1;
    localparam logic [3:0] OS_G3_TS1 = 4'd2;
    localparam logic [3:0] OS_G3_TS2 = 4'd3;
    localparam logic [3:0] OS_G4_TS1 = 4'd4;
    localparam logic [3:0] OS_G4_TS2 = 4'd5;
    localparam logic [3:0] OS_G4_TS3 = 4'd6;
    localparam logic [3:0] OS_G4_TS4 = 4'd7;
    localparam logic [3:0] OS_DATA   = 4'd8;
    localparam logic [3:0] OS_NONE   = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COUNT,
        ST_DONE,
        ST_TIMEOUT
    } os_q_state_t;

    // True for codes that name a real ordered set (not data / none / reserved).
    function automatic logic is_os_code(input logic [3:0] code);
        return code <= OS_G4_TS4;
    endfunction

endpackage

// File: rtl/os_rx_qualifier_if.sv
// LTSSM <-> qualifier bundle. master = LTSSM/receive side, slave = qualifier.
// cnt_l0/cnt_l1 expose the live per-lane run lengths for observation.
interface os_rx_qualifier_if #(
    parameter int CNT_W = 5
);
    logic             lane_rx_on;
    logic [3:0]       d_sel;
    logic [3:0]       os_in_l0;
    logic [3:0]       os_in_l1;
    logic             os_rec_done;
    logic [3:0]       os_rec_code;
    logic             lane_ok_l0;
    logic             lane_ok_l1;
    logic             os_timeout;
    logic [CNT_W-1:0] cnt_l0;
    logic [CNT_W-1:0] cnt_l1;

    modport master (
        output lane_rx_on, d_sel, os_in_l0, os_in_l1,
        input  os_rec_done, os_rec_code, lane_ok_l0, lane_ok_l1, os_timeout,
        input  cnt_l0, cnt_l1
    );

    modport slave (
        input  lane_rx_on, d_sel, os_in_l0, os_in_l1,
        output os_rec_done, os_rec_code, lane_ok_l0, lane_ok_l1, os_timeout,
        output cnt_l0, cnt_l1
    );
endinterface

// File: rtl/os_rx_qualifier_lane_counter.sv
// Per-lane consecutive ordered-set counter. Counts matches while enabled,
// holds on "no code", restarts the run on any other code. Saturates.
module os_lane_counter
    import os_rx_qualifier_pkg::*;
#(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [3:0]       exp_code_i,
    input  logic [3:0]       os_in_i,
    input  logic [CNT_W-1:0] req_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ok_o,
    output logic             next_ok_o
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ok_q;

    // Next run length from this cycle's code.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (os_in_i == exp_code_i) begin
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
            end else if (os_in_i != OS_NONE) begin
                cnt_d = '0;
            end
        end
    end

    assign next_ok_o = (cnt_d >= req_i);

    // Count and qualified flag; both freeze while not enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            ok_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (clr_i)     ok_q <= 1'b0;
            else if (en_i) ok_q <= next_ok_o;
        end
    end

    assign cnt_o = cnt_q;
    assign ok_o  = ok_q;
endmodule

// File: rtl/os_rx_qualifier.sv
// Two-lane ordered-set qualifier: waits for the required run of the expected
// code on both lanes, or flags a timeout. Results are sticky until the LTSSM
// changes the expected code or drops receive enable.
module os_rx_qualifier
    import os_rx_qualifier_pkg::*;
#(
    parameter int REQ_CNT_SLOS = 2,
    parameter int REQ_CNT_TS   = 16,
    parameter int CNT_W        = 5,
    parameter int TIMEOUT_CYC  = 4096,
    parameter int TO_W         = 13
) (
    input  logic                clk,
    input  logic                rst,
    os_rx_qualifier_if.slave    bus
);
    if (REQ_CNT_SLOS > 2**CNT_W-1 || REQ_CNT_TS > 2**CNT_W-1) begin : g_chk_cnt
        $error("REQ_CNT_* does not fit in CNT_W");
    end
    if (TIMEOUT_CYC > 2**TO_W-1) begin : g_chk_to
        $error("TIMEOUT_CYC does not fit in TO_W");
    end

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    os_q_state_t      state_q;
    logic [3:0]       exp_code_q;
    logic [TO_W-1:0]  to_cnt_q;
    logic             done_q;
    logic [3:0]       code_q;
    logic             timeout_q;

    logic [CNT_W-1:0] req;
    logic             lane_clr, lane_en;
    logic             next_ok_l0, next_ok_l1;

    assign req      = (exp_code_q <= OS_SLOS2) ? CNT_W'(REQ_CNT_SLOS) : CNT_W'(REQ_CNT_TS);
    // Lanes restart whenever the FSM is (or is about to be) back in IDLE.
    assign lane_clr = !bus.lane_rx_on || (state_q == ST_IDLE) || (bus.d_sel != exp_code_q);
    assign lane_en  = (state_q == ST_COUNT);

    os_lane_counter #(.CNT_W(CNT_W)) u_lane0 (
        .clk(clk), .rst(rst), .en_i(lane_en), .clr_i(lane_clr),
        .exp_code_i(exp_code_q), .os_in_i(bus.os_in_l0), .req_i(req),
        .cnt_o(bus.cnt_l0), .ok_o(bus.lane_ok_l0), .next_ok_o(next_ok_l0)
    );

    os_lane_counter #(.CNT_W(CNT_W)) u_lane1 (
        .clk(clk), .rst(rst), .en_i(lane_en), .clr_i(lane_clr),
        .exp_code_i(exp_code_q), .os_in_i(bus.os_in_l1), .req_i(req),
        .cnt_o(bus.cnt_l1), .ok_o(bus.lane_ok_l1), .next_ok_o(next_ok_l1)
    );

    // Qualification FSM with timeout counter and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst || !bus.lane_rx_on) begin
            state_q    <= ST_IDLE;
            exp_code_q <= OS_NONE;
            to_cnt_q   <= '0;
            done_q     <= 1'b0;
            code_q     <= OS_NONE;
            timeout_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (is_os_code(bus.d_sel)) begin
                        state_q    <= ST_COUNT;
                        exp_code_q <= bus.d_sel;
                        to_cnt_q   <= '0;
                    end
                end
                ST_COUNT: begin
                    if (bus.d_sel != exp_code_q) begin
                        state_q <= ST_IDLE;
                    end else if (next_ok_l0 && next_ok_l1) begin
                        // Qualification outranks a coincident timeout.
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        code_q  <= exp_code_q;
                    end else if (to_cnt_q == TO_LAST) begin
                        state_q   <= ST_TIMEOUT;
                        timeout_q <= 1'b1;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                ST_DONE, ST_TIMEOUT: begin
                    if (bus.d_sel != exp_code_q) begin
                        state_q   <= ST_IDLE;
                        done_q    <= 1'b0;
                        code_q    <= OS_NONE;
                        timeout_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.os_rec_done = done_q;
    assign bus.os_rec_code = code_q;
    assign bus.os_timeout  = timeout_q;
endmodule
